tdes_decrypt_ctrl: RTL and testbench

- Triple-DES (EDE) decryption sequencer. Takes one 64-bit ciphertext block and three 64-bit keys over a valid/ready handshake.
- Drives a single external DES core (16-round pipeline plus key generator, fixed latency) through three passes: D(K3), then E(K2), then D(K1).
- Returns the plaintext over a valid/ready handshake. It is the decrypt-direction counterpart of the team's 3DES encrypt path and sits between the bus interface and the DES core.

---
 rtl/tdes_decrypt_ctrl.sv | 154 +++++++++++++++
 tb/tb_tdes_decrypt_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdes_decrypt_ctrl.sv
// Triple-DES EDE decrypt sequencer: runs one external DES core through D(K3), E(K2), D(K1)
// and returns the plaintext over a valid/ready handshake.
module tdes_decrypt_ctrl #(
    parameter int unsigned CORE_LATENCY = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher_in,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain_out,
    output logic        busy,
    output logic [63:0] core_data,
    output logic [63:0] core_key,
    output logic        core_decrypt,
    input  logic [63:0] core_result
);

    localparam logic [7:0] CntLoad = 8'(CORE_LATENCY);

    typedef enum logic [2:0] {
        StIdle,
        StPass1,
        StPass2,
        StPass3,
        StOut
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] key1_q, key1_d;
    logic [63:0] key2_q, key2_d;
    logic [63:0] core_data_q, core_data_d;
    logic [63:0] core_key_q, core_key_d;
    logic        core_decrypt_q, core_decrypt_d;
    logic [63:0] plain_q, plain_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        pass_done;

    // The core result is only trusted on the cycle the latency counter has run out.
    assign pass_done = (cnt_q == 8'd0);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        key1_d         = key1_q;
        key2_d         = key2_q;
        core_data_d    = core_data_q;
        core_key_d     = core_key_q;
        core_decrypt_d = core_decrypt_q;
        plain_d        = plain_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Key 3 goes straight to the core; keys 1 and 2 are held for later passes.
                    key1_d         = key1;
                    key2_d         = key2;
                    core_data_d    = cipher_in;
                    core_key_d     = key3;
                    core_decrypt_d = 1'b1;
                    cnt_d          = CntLoad;
                    state_d        = StPass1;
                end
            end
            StPass1: begin
                if (!pass_done) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    core_data_d    = core_result;
                    core_key_d     = key2_q;
                    core_decrypt_d = 1'b0;
                    cnt_d          = CntLoad;
                    state_d        = StPass2;
                end
            end
            StPass2: begin
                if (!pass_done) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    core_data_d    = core_result;
                    core_key_d     = key1_q;
                    core_decrypt_d = 1'b1;
                    cnt_d          = CntLoad;
                    state_d        = StPass3;
                end
            end
            StPass3: begin
                if (!pass_done) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    plain_d = core_result;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StOut);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            cnt_q          <= 8'd0;
            key1_q         <= 64'd0;
            key2_q         <= 64'd0;
            core_data_q    <= 64'd0;
            core_key_q     <= 64'd0;
            core_decrypt_q <= 1'b0;
            plain_q        <= 64'd0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            key1_q         <= key1_d;
            key2_q         <= key2_d;
            core_data_q    <= core_data_d;
            core_key_q     <= core_key_d;
            core_decrypt_q <= core_decrypt_d;
            plain_q        <= plain_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign plain_out    = plain_q;
    assign core_data    = core_data_q;
    assign core_key     = core_key_q;
    assign core_decrypt = core_decrypt_q;

endmodule

// File: tb/tb_tdes_decrypt_ctrl.sv
// Directed bench for tdes_decrypt_ctrl with a fixed-latency DES core model that knows the
// classic DES vector and falls back to a keyed scramble for any other input.
module tb_tdes_decrypt_ctrl;

    localparam int LAT = 20;
    localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] CIPH  = 64'h85E813540F0AB405;
    localparam logic [63:0] PLAIN = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] cipher_in;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plain_out;
    logic        busy;
    logic [63:0] core_data;
    logic [63:0] core_key;
    logic        core_decrypt;
    logic [63:0] core_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdes_decrypt_ctrl #(.CORE_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cipher_in    (cipher_in),
        .key1         (key1),
        .key2         (key2),
        .key3         (key3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .plain_out    (plain_out),
        .busy         (busy),
        .core_data    (core_data),
        .core_key     (core_key),
        .core_decrypt (core_decrypt),
        .core_result  (core_result)
    );

    function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k,
                                            input logic dec);
        if (dec && k == KEY && d == CIPH) return PLAIN;
        if (!dec && k == KEY && d == PLAIN) return CIPH;
        return {d[50:0], d[63:51]} ^ k ^ (dec ? 64'hA5A50F0F3C3C9696 : 64'h123456789ABCDEF0);
    endfunction

    // Core model: result reflects the inputs seen LAT edges earlier.
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= core_fn(core_data, core_key, core_decrypt);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_result = pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge.
    task automatic start_block(input logic [63:0] c, input logic [63:0] k1v,
                               input logic [63:0] k2v, input logic [63:0] k3v);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_ready got=%b exp=1", in_ready);
        end
        cipher_in = c;
        key1 = k1v;
        key2 = k2v;
        key3 = k3v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cipher_in = '0;
        key1 = '0;
        key2 = '0;
        key3 = '0;
        #2 reset = 1'b0;
        #10;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (plain_out !== 64'd0) begin bad++; $display("FAIL rst_plain got=%h exp=0", plain_out); end
        total++; if (core_data !== 64'd0) begin bad++; $display("FAIL rst_core_data got=%h exp=0", core_data); end
        total++; if (core_key !== 64'd0) begin bad++; $display("FAIL rst_core_key got=%h exp=0", core_key); end
        total++; if (core_decrypt !== 1'b0) begin bad++; $display("FAIL rst_core_dec got=%b exp=0", core_decrypt); end
        #10 reset = 1'b1;
        tick();
    endtask

    task automatic test_single_des();
        logic [63:0] captured = '0;
        logic        ed;
        start_block(CIPH, KEY, KEY, KEY);
        total++; if (core_data !== CIPH) begin bad++; $display("FAIL sd_core_data0 got=%h exp=%h", core_data, CIPH); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sd_busy got=%b exp=1", busy); end
        for (int n = 0; n < 63; n++) begin
            ed = !(n >= 21 && n < 42);
            total++; if (core_decrypt !== ed) begin bad++; $display("FAIL sd_dec n=%0d got=%b exp=%b", n, core_decrypt, ed); end
            total++; if (core_key !== KEY) begin bad++; $display("FAIL sd_key n=%0d got=%h exp=%h", n, core_key, KEY); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sd_early_valid n=%0d got=%b exp=0", n, out_valid); end
            if (n == 20) captured = core_result;
            if (n == 21) begin
                total++; if (core_data !== captured) begin bad++; $display("FAIL sd_handover got=%h exp=%h", core_data, captured); end
                total++; if (core_data !== PLAIN) begin bad++; $display("FAIL sd_pass1 got=%h exp=%h", core_data, PLAIN); end
            end
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sd_out_valid got=%b exp=1", out_valid); end
        total++; if (plain_out !== PLAIN) begin bad++; $display("FAIL sd_plain got=%h exp=%h", plain_out, PLAIN); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sd_out_drop got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sd_ready_back got=%b exp=1", in_ready); end
    endtask

    task automatic test_pass_sequence();
        logic [63:0] c  = 64'hDEADBEEFCAFEF00D;
        logic [63:0] k1 = 64'h0F1E2D3C4B5A6978;
        logic [63:0] k2 = 64'h1122334455667788;
        logic [63:0] k3 = 64'hA0B1C2D3E4F50617;
        logic [63:0] e1, e2, e3, ek;
        logic        ed;
        e1 = core_fn(c, k3, 1'b1);
        e2 = core_fn(e1, k2, 1'b0);
        e3 = core_fn(e2, k1, 1'b1);
        start_block(c, k1, k2, k3);
        for (int n = 0; n < 63; n++) begin
            ek = (n < 21) ? k3 : (n < 42) ? k2 : k1;
            ed = !(n >= 21 && n < 42);
            total++; if (core_key !== ek) begin bad++; $display("FAIL ps_key n=%0d got=%h exp=%h", n, core_key, ek); end
            total++; if (core_decrypt !== ed) begin bad++; $display("FAIL ps_dec n=%0d got=%b exp=%b", n, core_decrypt, ed); end
            if (n == 21) begin
                total++; if (core_data !== e1) begin bad++; $display("FAIL ps_data2 got=%h exp=%h", core_data, e1); end
            end
            if (n == 42) begin
                total++; if (core_data !== e2) begin bad++; $display("FAIL ps_data3 got=%h exp=%h", core_data, e2); end
            end
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ps_out_valid got=%b exp=1", out_valid); end
        total++; if (plain_out !== e3) begin bad++; $display("FAIL ps_plain got=%h exp=%h", plain_out, e3); end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        start_block(CIPH, KEY, KEY, KEY);
        wait_out(cyc);
        total++; if (cyc != 63) begin bad++; $display("FAIL bp_latency got=%0d exp=63", cyc); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, out_valid); end
            total++; if (plain_out !== PLAIN) begin bad++; $display("FAIL bp_plain i=%0d got=%h exp=%h", i, plain_out, PLAIN); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready i=%0d got=%b exp=0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
        out_ready = 1'b1;
    endtask

    task automatic test_key_isolation();
        int cyc;
        start_block(CIPH, KEY, KEY, KEY);
        key1 = '1;
        key2 = '1;
        key3 = '1;
        wait_out(cyc);
        total++; if (cyc != 63) begin bad++; $display("FAIL ki_latency got=%0d exp=63", cyc); end
        total++; if (plain_out !== PLAIN) begin bad++; $display("FAIL ki_plain got=%h exp=%h", plain_out, PLAIN); end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_block(CIPH, KEY, KEY, KEY);
        repeat (30) tick();
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
        total++; if (core_key !== 64'd0) begin bad++; $display("FAIL rm_core_key got=%h exp=0", core_key); end
        total++; if (core_decrypt !== 1'b0) begin bad++; $display("FAIL rm_core_dec got=%b exp=0", core_decrypt); end
        #2 reset = 1'b1;
        tick();
        start_block(CIPH, KEY, KEY, KEY);
        wait_out(cyc);
        total++; if (cyc != 63) begin bad++; $display("FAIL rm_latency got=%0d exp=63", cyc); end
        total++; if (plain_out !== PLAIN) begin bad++; $display("FAIL rm_plain got=%h exp=%h", plain_out, PLAIN); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] c2 = 64'h0011223344556677;
        logic [63:0] k1 = 64'h8899AABBCCDDEEFF;
        logic [63:0] k2 = 64'h7766554433221100;
        logic [63:0] k3 = 64'h0123012301230123;
        logic [63:0] exp2;
        exp2 = core_fn(core_fn(core_fn(c2, k3, 1'b1), k2, 1'b0), k1, 1'b1);
        out_ready = 1'b1;
        start_block(CIPH, KEY, KEY, KEY);
        in_valid = 1'b1;
        wait_out(cyc);
        total++; if (cyc != 63) begin bad++; $display("FAIL bb_latency1 got=%0d exp=63", cyc); end
        total++; if (plain_out !== PLAIN) begin bad++; $display("FAIL bb_plain1 got=%h exp=%h", plain_out, PLAIN); end
        cipher_in = c2;
        key1 = k1;
        key2 = k2;
        key3 = k3;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bb_valid_drop got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bb_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bb_accept2 got=%b exp=1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bb_ready2 got=%b exp=0", in_ready); end
        wait_out(cyc);
        total++; if (cyc != 63) begin bad++; $display("FAIL bb_latency2 got=%0d exp=63", cyc); end
        total++; if (plain_out !== exp2) begin bad++; $display("FAIL bb_plain2 got=%h exp=%h", plain_out, exp2); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bb_one_shot got=%b exp=0", out_valid); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bb_no_third got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_des();
        test_pass_sequence();
        test_backpressure();
        test_key_isolation();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
